ir_wand_tx: RTL and testbench

//  Transmit side of the IR wand link: serialises an 8-bit spell code into a pulse-distance IR frame on a carrier.
//  The output drives the wand's IR LED; the 25-receiver array that feeds ir_in on the graphics side decodes it.

---
 rtl/ir_pkg.sv | 25 ++
 rtl/ir_carrier_gen.sv | 33 +++
 rtl/ir_wand_tx.sv | 92 +++++++++
 tb/tb_ir_wand_tx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared FSM states, frame timing constants and phase-length lookup for the IR wand transmitter.
package ir_pkg;
   typedef enum logic [2:0] {IDLE, HDR_MARK, HDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP} state_t;
   localparam int unsigned HDR_MARK_U   = 16;
   localparam int unsigned HDR_SPACE_U  = 8;
   localparam int unsigned BIT_MARK_U   = 1;
   localparam int unsigned BIT0_SPACE_U = 1;
   localparam int unsigned BIT1_SPACE_U = 3;
   localparam int unsigned STOP_MARK_U  = 1;
   localparam int unsigned FRAME_W      = 16;
   localparam int unsigned FRAME_U      = HDR_MARK_U + HDR_SPACE_U + FRAME_W * BIT_MARK_U
                                          + (FRAME_W / 2) * (BIT0_SPACE_U + BIT1_SPACE_U) + STOP_MARK_U;

   function automatic int unsigned phase_units(input state_t s, input logic bit_val, input int unsigned gap_u);
      return s == HDR_MARK  ? HDR_MARK_U :
             s == HDR_SPACE ? HDR_SPACE_U :
             s == BIT_SPACE ? (bit_val ? BIT1_SPACE_U : BIT0_SPACE_U) :
             s == GAP       ? gap_u :
             s == STOP_MARK ? STOP_MARK_U : BIT_MARK_U;
   endfunction

   function automatic logic is_mark(input state_t s);
      return s == HDR_MARK || s == BIT_MARK || s == STOP_MARK;
   endfunction
endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: registered square-wave carrier that restarts high on every mark entry and is cut when en drops.
module ir_carrier_gen #(
   parameter int unsigned HALF_CARRIER = 658
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic restart,
   input  logic en,
   output logic carrier
);
   localparam int unsigned CW = $clog2(HALF_CARRIER) + 1;

   logic [CW-1:0] cnt;
   logic          half_end;

   assign half_end = cnt == CW'(HALF_CARRIER - 1);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         carrier <= 1'b0;
      end else if (restart) begin
         cnt     <= '0;
         carrier <= 1'b1;
      end else if (en) begin
         cnt     <= half_end ? '0 : cnt + 1'b1;
         carrier <= half_end ? ~carrier : carrier;
      end else begin
         cnt     <= '0;
         carrier <= 1'b0;
      end
   end
endmodule

// File: rtl/ir_wand_tx.sv
// ir_wand_tx: serialises an 8-bit spell code into a pulse-distance IR frame on a carrier.
module ir_wand_tx
   import ir_pkg::*;
#(
   parameter int unsigned UNIT_CYC     = 28125,
   parameter int unsigned HALF_CARRIER = 658,
   parameter int unsigned GAP_U        = 40
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] spell_id,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       ir_out
);
   localparam int unsigned CW = $clog2(UNIT_CYC + 1);
   localparam int unsigned UW = $clog2((GAP_U > HDR_MARK_U ? GAP_U : HDR_MARK_U) + 1);

   state_t             state;
   logic [CW-1:0]      cyc_cnt;
   logic [UW-1:0]      unit_cnt;
   logic [FRAME_W-1:0] sr;
   logic [3:0]         idx;
   logic               unit_end, phase_end, accept, restart, en;

   assign unit_end  = cyc_cnt == CW'(UNIT_CYC - 1);
   assign phase_end = unit_end && unit_cnt == UW'(phase_units(state, sr[0], GAP_U) - 1);
   assign accept    = state == IDLE && start;
   // Every space that ends leads into a mark (HDR_SPACE->BIT_MARK, BIT_SPACE->BIT/STOP_MARK).
   assign restart   = accept || (phase_end && (state == HDR_SPACE || state == BIT_SPACE));
   assign en        = is_mark(state) && !phase_end;
   assign ready     = ~busy;

   ir_carrier_gen #(.HALF_CARRIER(HALF_CARRIER)) u_carrier (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .restart  (restart),
      .en       (en),
      .carrier  (ir_out)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         unit_cnt <= '0;
         sr       <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            if (start) begin
               sr    <= {~spell_id, spell_id};
               idx   <= '0;
               busy  <= 1'b1;
               state <= HDR_MARK;
            end
         end else if (phase_end) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            case (state)
               HDR_MARK:  state <= HDR_SPACE;
               HDR_SPACE: state <= BIT_MARK;
               BIT_MARK:  state <= BIT_SPACE;
               BIT_SPACE: begin
                  sr    <= sr >> 1;
                  idx   <= idx + 1'b1;
                  state <= idx == 4'(FRAME_W - 1) ? STOP_MARK : BIT_MARK;
               end
               STOP_MARK: begin
                  done  <= 1'b1;
                  state <= GAP;
               end
               GAP: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default:   state <= IDLE;
            endcase
         end else begin
            cyc_cnt  <= unit_end ? '0 : cyc_cnt + 1'b1;
            unit_cnt <= unit_end ? unit_cnt + 1'b1 : unit_cnt;
         end
      end
   end
endmodule

// File: tb/tb_ir_wand_tx.sv
// tb_ir_wand_tx: randomized and directed frames checked cycle-by-cycle against a waveform-table model of the IR frame.
module tb_ir_wand_tx;
   localparam int UNIT     = 20;
   localparam int HALF     = 2;
   localparam int GAP      = 40;
   localparam int DONE_POS = 73 * UNIT;
   localparam int T        = (73 + GAP) * UNIT;

   logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [7:0] spell_id = '0;
   logic       ready, busy, done, ir_out;

   int   n_cmp = 0, n_bad = 0;
   logic wave [T];
   int   wp = 0;
   logic m_busy = 1'b0;
   int   m_pos = 0;

   ir_wand_tx #(.UNIT_CYC(UNIT), .HALF_CARRIER(HALF), .GAP_U(GAP)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .spell_id (spell_id),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .ir_out   (ir_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic put(input bit mark, input int len);
      for (int k = 0; k < len; k++) begin
         wave[wp] = mark && ((k / HALF) % 2 == 0);
         wp++;
      end
   endtask

   // Expected LED waveform of one frame plus gap, starting the cycle after acceptance.
   task automatic build(input logic [7:0] id);
      logic [15:0] d;
      d  = {~id, id};
      wp = 0;
      put(1, 16 * UNIT);
      put(0, 8 * UNIT);
      for (int b = 0; b < 16; b++) begin
         put(1, UNIT);
         put(0, (d[b] ? 3 : 1) * UNIT);
      end
      put(1, UNIT);
      put(0, GAP * UNIT);
   endtask

   task automatic cyc(input logic s, input logic [7:0] id);
      start    = s;
      spell_id = id;
      @(posedge clk);
      if (m_busy) begin
         m_pos++;
         if (m_pos == T) m_busy = 1'b0;
      end else if (s) begin
         build(id);
         m_busy = 1'b1;
         m_pos  = 0;
      end
      @(negedge clk);
      chk("ir_out", 32'(ir_out), 32'(m_busy ? wave[m_pos] : 1'b0));
      chk("busy",   32'(busy),   32'(m_busy));
      chk("ready",  32'(ready),  32'(!m_busy));
      chk("done",   32'(done),   32'(m_busy && m_pos == DONE_POS));
   endtask

   task automatic drain(input logic [7:0] id);
      for (int i = 0; i < T + 2 && m_busy; i++) cyc(1'b0, id);
      cyc(1'b0, id);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ir_out", 32'(ir_out), 0);
      chk("rst_busy",   32'(busy),   0);
      chk("rst_ready",  32'(ready),  1);
      chk("rst_done",   32'(done),   0);
      reset = 1'b0;

      cyc(1'b1, 8'hA5);
      repeat (T + 3) cyc(1'b1, 8'h3C);
      drain(8'h00);

      cyc(1'b1, 8'hA5);
      repeat (680) cyc(1'b0, 8'h00);
      for (int i = 0; i < 200 && !(m_busy && wave[m_pos]); i++) cyc(1'b0, 8'h00);
      chk("pre_rst_ir_out", 32'(ir_out), 1);
      #1 reset = 1'b1;
      #1;
      chk("async_ir_out", 32'(ir_out), 0);
      chk("async_busy",   32'(busy),   0);
      chk("async_done",   32'(done),   0);
      chk("async_ready",  32'(ready),  1);
      m_busy = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 8'h55);
      cyc(1'b1, 8'h01);
      drain(8'h01);

      cyc(1'b1, 8'h11);
      repeat (4) cyc(1'b0, 8'h11);
      drain(8'hFF);

      cyc(1'b1, 8'h00); drain(8'hFF);
      cyc(1'b1, 8'hFF); drain(8'h00);
      cyc(1'b1, 8'h80); drain(8'h7F);

      repeat (4) begin
         repeat ($urandom_range(0, 30)) cyc(1'b0, 8'($urandom));
         repeat (T + 40) cyc($urandom_range(0, 3) == 0, 8'($urandom));
      end
      drain(8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
